// File: rtl/bsg_async_fifo_pkg.sv
// Shared async FIFO helpers: pointer width, occupancy type, gray/binary conversion.
// Used by the write-side (and read-side) controllers.
package bsg_async_fifo_pkg;

    localparam int lg_size_default_lp = 4;

    typedef logic [lg_size_default_lp:0] occ_t;

    function automatic int ptr_width(input int lg_size);
        return lg_size + 1;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/bsg_async_fifo_w_ctrl_if.sv
// Producer-side handshake and memory write port of the async FIFO write controller.
// Controller uses the slave modport; the producer/memory side uses master.
interface bsg_async_fifo_w_ctrl_if #(
    parameter int lg_size_p = 4
);
    logic                 w_v_i;
    logic                 w_ready_o;
    logic                 w_enq_o;
    logic [lg_size_p-1:0] w_addr_o;

    modport master (
        output w_v_i,
        input  w_ready_o,
        input  w_enq_o,
        input  w_addr_o
    );

    modport slave (
        input  w_v_i,
        output w_ready_o,
        output w_enq_o,
        output w_addr_o
    );
endinterface

// File: rtl/bsg_gray_to_binary.sv
// Gray to binary converter: each binary bit is the XOR of all gray bits at or above it.
// Shared by the write- and read-side controllers.
module bsg_gray_to_binary #(
    parameter int width_p = 5
) (
    input  logic [width_p-1:0] gray_i,
    output logic [width_p-1:0] binary_o
);

    for (genvar i = 0; i < width_p; i++) begin : g_bit
        assign binary_o[i] = ^gray_i[width_p-1:i];
    end

endmodule

// File: rtl/bsg_async_fifo_w_ctrl.sv
// Async FIFO write-domain controller: enqueue gating, write address, occupancy and error.
// Optional saturating stall counter under BSG_ASYNC_FIFO_W_CTRL_STALL_CNT_EN.
module bsg_async_fifo_w_ctrl
    import bsg_async_fifo_pkg::*;
#(
    parameter int lg_size_p = 4,
    parameter int stall_w_p = 16
) (
    input  logic                                w_clk_i,
    input  logic                                w_reset_i,
    bsg_async_fifo_w_ctrl_if.slave              w_if,
    input  logic [ptr_width(lg_size_p)-1:0]     w_ptr_binary_i,
    input  logic [ptr_width(lg_size_p)-1:0]     r_ptr_gray_wsync_i,
    output logic [ptr_width(lg_size_p)-1:0]     w_occupancy_o,
    output logic                                w_err_o
`ifdef BSG_ASYNC_FIFO_W_CTRL_STALL_CNT_EN
    ,
    output logic [stall_w_p-1:0]                w_stall_cnt_o
`endif
);

    localparam int ptr_w_lp = ptr_width(lg_size_p);
    localparam logic [ptr_w_lp-1:0] depth_lp = ptr_w_lp'(1) << lg_size_p;

    if (lg_size_p < 1 || stall_w_p < 1) begin : g_bad_param
        $error("bsg_async_fifo_w_ctrl: lg_size_p and stall_w_p must be >= 1");
    end

    logic [ptr_w_lp-1:0] r_bin_n;
    logic [ptr_w_lp-1:0] w_bin_n;
    logic [ptr_w_lp-1:0] occ_n;
    logic [ptr_w_lp-1:0] occ_r;
    logic                full_r;
    logic                err_r;

    bsg_gray_to_binary #(
        .width_p (ptr_w_lp)
    ) g2b (
        .gray_i   (r_ptr_gray_wsync_i),
        .binary_o (r_bin_n)
    );

    // occ_r already includes every enq up to last cycle, so full can never overrun
    assign full_r         = (occ_r == depth_lp);
    assign w_if.w_ready_o = ~full_r & ~w_reset_i;
    assign w_if.w_enq_o   = w_if.w_v_i & w_if.w_ready_o;
    assign w_if.w_addr_o  = w_ptr_binary_i[lg_size_p-1:0];

    assign w_bin_n = w_ptr_binary_i + ptr_w_lp'(w_if.w_enq_o);
    assign occ_n   = w_bin_n - r_bin_n;

    always_ff @(posedge w_clk_i) begin
        if (w_reset_i) begin
            occ_r <= '0;
            err_r <= 1'b0;
        end else begin
            occ_r <= occ_n;
            err_r <= err_r | (occ_n > depth_lp);
        end
    end

    assign w_occupancy_o = occ_r;
    assign w_err_o       = err_r;

`ifdef BSG_ASYNC_FIFO_W_CTRL_STALL_CNT_EN
    logic [stall_w_p-1:0] stall_cnt_r;

    always_ff @(posedge w_clk_i) begin
        if (w_reset_i) begin
            stall_cnt_r <= '0;
        end else if (w_if.w_v_i & ~w_if.w_ready_o & ~(&stall_cnt_r)) begin
            stall_cnt_r <= stall_cnt_r + 1'b1;
        end
    end

    assign w_stall_cnt_o = stall_cnt_r;
`endif

endmodule

// File: tb/tb_bsg_async_fifo_w_ctrl.sv
// Directed-vector bench for the async FIFO write controller (lg_size_p=4).
// Holds a simple pointer-block model for the registered binary write pointer.
module tb_bsg_async_fifo_w_ctrl;
    import bsg_async_fifo_pkg::*;

    typedef struct {
        logic       rst;
        logic       v;
        logic [4:0] r_bin;
        logic       ready;
        logic       enq;
        occ_t       occ;
        logic [3:0] addr;
        logic       err;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;
    int   enq_seen;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] wptr;
    logic [4:0] rgray;
    logic [4:0] occ;
    logic       err;
`ifdef BSG_ASYNC_FIFO_W_CTRL_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    bsg_async_fifo_w_ctrl_if #(.lg_size_p(4)) w_if ();

    bsg_async_fifo_w_ctrl #(
        .lg_size_p (4),
        .stall_w_p (16)
    ) dut (
        .w_clk_i            (clk),
        .w_reset_i          (rst),
        .w_if               (w_if),
        .w_ptr_binary_i     (wptr),
        .r_ptr_gray_wsync_i (rgray),
        .w_occupancy_o      (occ),
        .w_err_o            (err)
`ifdef BSG_ASYNC_FIFO_W_CTRL_STALL_CNT_EN
        ,
        .w_stall_cnt_o      (stall_cnt)
`endif
    );

    // pointer block model: registered binary write pointer
    always_ff @(posedge clk) begin
        if (rst) wptr <= '0;
        else if (w_if.w_enq_o) wptr <= wptr + 5'd1;
    end

    function automatic void add(input logic r, input logic v, input int rb,
                                input logic rdy, input logic enq, input int o,
                                input int a, input logic e);
        vec_t x;
        x.rst = r; x.v = v; x.r_bin = 5'(rb);
        x.ready = rdy; x.enq = enq; x.occ = occ_t'(o);
        x.addr = 4'(a); x.err = e;
        tbl.push_back(x);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [4:0] rb);
        @(negedge clk);
        rst = r;
        w_if.w_v_i = v;
        rgray = rb ^ (rb >> 1);
        #1;
    endtask

    task automatic run(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            drive(tbl[i].rst, tbl[i].v, tbl[i].r_bin);
            if (w_if.w_enq_o === 1'b1) enq_seen++;
            chk($sformatf("row%0d ready", i), 32'(w_if.w_ready_o), 32'(tbl[i].ready));
            chk($sformatf("row%0d enq", i), 32'(w_if.w_enq_o), 32'(tbl[i].enq));
            chk($sformatf("row%0d occ", i), 32'(occ), 32'(tbl[i].occ));
            chk($sformatf("row%0d addr", i), 32'(w_if.w_addr_o), 32'(tbl[i].addr));
            chk($sformatf("row%0d err", i), 32'(err), 32'(tbl[i].err));
        end
    endtask

    initial begin
        int p0, p1, p2, p3, p5, p6;
        rst = 1'b1;
        w_if.w_v_i = 1'b0;
        rgray = '0;
        repeat (2) @(posedge clk);

        // reset state, enq suppressed while reset high
        add(1, 1, 0, 0, 0, 0, 0, 0);
        p0 = tbl.size();
        // fill: 16 enqs, then blocked
        for (int k = 0; k < 20; k++)
            add(0, 1, 0, k < 16, k < 16, (k < 16) ? k : 16, (k < 16) ? k : 0, 0);
        p1 = tbl.size();
        // single free from full
        add(0, 1, 1, 0, 0, 16, 0, 0);
        add(0, 1, 1, 1, 1, 15, 0, 0);
        add(0, 1, 1, 0, 0, 16, 1, 0);
        p2 = tbl.size();
        // drop to 8, then enq and free in the same cycle
        add(0, 0, 9, 0, 0, 16, 1, 0);
        add(0, 1, 10, 1, 1, 8, 1, 0);
        add(0, 1, 11, 1, 1, 8, 2, 0);
        add(0, 0, 11, 1, 0, 8, 3, 0);
        p3 = tbl.size();
        // read ptr 20 behind write ptr 27: occupancy 20, sticky error
        add(0, 0, 7, 1, 0, 8, 11, 0);
        add(0, 0, 27, 1, 0, 20, 11, 1);
        add(0, 0, 27, 1, 0, 0, 11, 1);
        add(0, 0, 27, 1, 0, 0, 11, 1);
        p5 = tbl.size();
        // reset clears error; refill to 5 then reset mid-stream
        add(1, 1, 0, 0, 0, 0, 11, 1);
        for (int k = 0; k < 5; k++)
            add(0, 1, 0, 1, 1, k, k, 0);
        add(1, 1, 0, 0, 0, 5, 5, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0);
        p6 = tbl.size();

        run(0, p0);
        enq_seen = 0;
        run(p0, p1);
        chk("fill enq count", 32'(enq_seen), 32'd16);
        run(p1, p2);
        run(p2, p3);

        // 40 enq/free pairs; write ptr wraps 31 -> 0 at i=12
        for (int i = 0; i < 40; i++) begin
            drive(1'b0, 1'b1, 5'((12 + i) & 31));
            chk($sformatf("wrap%0d occ", i), 32'(occ), 32'd8);
            chk($sformatf("wrap%0d enq", i), 32'(w_if.w_enq_o), 32'd1);
            chk($sformatf("wrap%0d addr", i), 32'(w_if.w_addr_o), 32'((19 + i) & 15));
            chk($sformatf("wrap%0d err", i), 32'(err), 32'd0);
        end

        run(p3, p5);
        run(p5, p6);

`ifdef BSG_ASYNC_FIFO_W_CTRL_STALL_CNT_EN
        chk("stall cnt after reset", 32'(stall_cnt), 32'd0);
        for (int k = 0; k < 16; k++) drive(1'b0, 1'b1, 5'd0);
        for (int k = 0; k < 7; k++) begin
            drive(1'b0, 1'b1, 5'd0);
            chk($sformatf("stall%0d ready", k), 32'(w_if.w_ready_o), 32'd0);
        end
        drive(1'b0, 1'b0, 5'd0);
        chk("stall cnt", 32'(stall_cnt), 32'd7);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
